vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Shares the single-port tile-map video RAM between the SVGA scan-out reader and the game-logic writer. Display reads have absolute priority and are never stalled. Game writes are buffered in a small FIFO and drained into free RAM cycles, optionally only during vertical blanking. A per-frame commit pulse tells game logic when every buffered write has landed before the next frame starts.

## Interface
Parameters:
- AW, 12, RAM address width.
- DW, 8, RAM data width.
- FIFO_DEPTH, 4, write-buffer entries; power of two, 2..16.
- VBLANK_ONLY, 0, 1 = drain writes only while v_nblank = 0.

Ports:
- sys_clk  in  1  system clock; one clock domain. All logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- disp_req  in  1  scan-out read request this cycle.
- disp_addr  in  AW  scan-out read address.
- disp_rvalid  out  1  read data valid; disp_req delayed by one cycle.
- disp_rdata  out  DW  read data, passed through from ram_rdata.
- wr_valid  in  1  game-logic write offer.
- wr_ready  out  1  FIFO not full (registered).
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- wr_pending  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- v_nblank  in  1  vertical active-video flag from the vertical timing FSM.
- EndFrame  in  1  one-cycle end-of-frame pulse from the vertical timing FSM.
- frame_commit  out  1  one-cycle pulse: the frame boundary was reached with all writes committed.
- ram_addr  out  AW  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DW  RAM write data.
- ram_rdata  in  DW  synchronous RAM read data; one-cycle latency.

## Operation
- **Write FIFO**
  - A push occurs when wr_valid && wr_ready. It stores {wr_addr, wr_data} at the write pointer.
  - A pop occurs in any drain cycle.
  - Pointers are clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave the count unchanged.
- **wr_ready**
  - Registered as count != FIFO_DEPTH, computed from the next-state count.
  - A push offered while full is ignored; wr_valid must be held by the producer.
- **Drain condition**
  - Drain when count != 0 && !disp_req && (VBLANK_ONLY == 0 || !v_nblank).
- **RAM port mux (combinational)**
  - disp_req = 1: ram_addr = disp_addr, ram_we = 0.
  - Else, drain: ram_addr/ram_wdata = FIFO head, ram_we = 1.
  - Else: ram_addr = disp_addr, ram_we = 0.
- **Read path**
  - disp_rvalid is a register loaded with disp_req.
  - disp_rdata = ram_rdata.
- **Hazard**
  - A display read of an address still in the FIFO returns the old RAM contents. This is accepted; the frame_commit pulse bounds the staleness to one frame.
- **Frame FSM (2 states)**
  - RUN:
    - On EndFrame with count == 0 and no push this cycle: pulse frame_commit next cycle, stay in RUN.
    - On EndFrame otherwise: go to FLUSH.
  - FLUSH:
    - When count becomes 0 (registered): pulse frame_commit and go to RUN.
    - EndFrame arriving while in FLUSH is absorbed, so there is no double pulse.
  - frame_commit is registered and high for exactly one cycle per commit.

## Timing
- **Reset values:** count = 0, both pointers = 0, wr_ready = 1, wr_pending = 0, disp_rvalid = 0, frame_commit = 0, FSM = RUN, ram_we = 0.
  - Reset mid-drain discards all FIFO contents.
- **Read latency:** disp_rvalid and valid disp_rdata appear exactly 1 cycle after disp_req. Back-to-back requests give one result per cycle.
- **Write latency:** minimum 1 cycle from push to ram_we. A push at cycle N is visible in the head and can drain at N+1.
- **Occupancy:** wr_pending updates on the edge after a push or pop.
- **Starvation:** with disp_req held high continuously, no write drains and wr_ready falls once the FIFO holds FIFO_DEPTH entries. Horizontal blanking cycles, where disp_req = 0, resume draining.
- **VBLANK_ONLY = 1:** no ram_we while v_nblank = 1, even if disp_req = 0.

## Test plan
- **Reset:** assert reset asynchronously mid-cycle with 3 entries pending -> wr_pending = 0, wr_ready = 1, ram_we = 0 immediately; no write reaches RAM after release.
- **Read priority:** disp_req = 1 at addr 0x010, wr_valid = 1 at addr 0x020 data 0x5A in the same cycle -> ram_addr = 0x010 with ram_we = 0. Next cycle, with disp_req = 0, ram_addr = 0x020, ram_we = 1, ram_wdata = 0x5A. disp_rvalid = 1 in the cycle after the read.
- **Full:** disp_req held high, 5 pushes offered with FIFO_DEPTH = 4 -> the first 4 are accepted, wr_ready = 0, the 5th is held. Drop disp_req for 4 cycles -> 4 writes drain in FIFO order, and wr_ready returns 1 after the first drain.
- **Simultaneous push/pop:** count = 2, push and drain in the same cycle -> wr_pending stays 2; pointers wrap correctly over 10 iterations.
- **VBLANK_ONLY = 1:** push 2 writes while v_nblank = 1 with disp_req = 0 -> no ram_we. Set v_nblank = 0 -> 2 consecutive ram_we cycles.
- **Frame commit:** EndFrame with FIFO empty -> one frame_commit pulse the next cycle. EndFrame with 3 pending -> FSM enters FLUSH, and frame_commit pulses once the cycle after count reaches 0. A second EndFrame during FLUSH produces no extra pulse.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// rtl/vram_arbiter_if.sv - bus bundle between the vram arbiter and its clients
//
// Groups the scan-out read port, the game-logic write port, the frame timing
// inputs and the single-port RAM port.
//   slave  : arbiter side (drives read data/valid, write ready/occupancy,
//            frame_commit and the RAM address/write signals)
//   master : environment side (scan-out, game logic, timing FSM, RAM)
interface vram_arbiter_if #(
  parameter int AW         = 12,
  parameter int DW         = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_rvalid;
  logic [DW-1:0] disp_rdata;

  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CW-1:0] wr_pending;

  logic          v_nblank;
  logic          EndFrame;
  logic          frame_commit;

  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_addr,
    output disp_rvalid, disp_rdata,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready, wr_pending,
    input  v_nblank, EndFrame,
    output frame_commit,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output disp_req, disp_addr,
    input  disp_rvalid, disp_rdata,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready, wr_pending,
    output v_nblank, EndFrame,
    input  frame_commit,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - tile-map VRAM arbiter: scan-out reads vs buffered game writes
//
// Display reads always own the RAM port. Game writes go into a small FIFO and
// drain into cycles with no display read (optionally only during vertical
// blanking). frame_commit pulses once per frame when every buffered write has
// reached RAM.
// Ports:
//   sys_clk : system clock, rising edge
//   reset   : asynchronous active-high reset
//   bus     : vram_arbiter_if.slave (read port, write port, frame timing, RAM port)
module vram_arbiter #(
  parameter int AW          = 12,
  parameter int DW          = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int VBLANK_ONLY = 0
) (
  input logic           sys_clk,
  input logic           reset,
  vram_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } frame_state_t;

  logic [AW-1:0] addr_mem [FIFO_DEPTH];
  logic [DW-1:0] data_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          ready_q;
  logic          rvalid_q;
  logic          commit_q;
  logic          commit_next;
  logic          push;
  logic          drain;
  frame_state_t  state;
  frame_state_t  state_next;

  assign push  = bus.wr_valid && ready_q;
  // A drain cycle is any cycle the display leaves the port idle, gated by
  // vertical blanking when writes must stay out of active video.
  assign drain = (count != '0) && !bus.disp_req && ((VBLANK_ONLY == 0) || !bus.v_nblank);

  always_comb begin
    count_next = count;
    if (push && !drain) begin
      count_next = count + 1'b1;
    end else if (!push && drain) begin
      count_next = count - 1'b1;
    end
  end

  // FIFO storage needs no reset: entries are only read when counted.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= bus.wr_addr;
      data_mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      commit_q <= 1'b0;
      state    <= RUN;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (drain) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count    <= count_next;
      ready_q  <= (count_next != FULL_COUNT);
      rvalid_q <= bus.disp_req;
      commit_q <= commit_next;
      state    <= state_next;
    end
  end

  // Frame FSM: RUN commits immediately when nothing is buffered at the frame
  // boundary; otherwise FLUSH waits for the FIFO to empty. EndFrame seen in
  // FLUSH is ignored so one flush yields one pulse.
  always_comb begin
    state_next  = state;
    commit_next = 1'b0;
    case (state)
      RUN: begin
        if (bus.EndFrame) begin
          if ((count == '0) && !push) begin
            commit_next = 1'b1;
          end else begin
            state_next = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (count == '0) begin
          commit_next = 1'b1;
          state_next  = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // RAM port: display address unless a write drains this cycle.
  always_comb begin
    bus.ram_addr  = bus.disp_addr;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = data_mem[rd_ptr];
    if (drain) begin
      bus.ram_addr = addr_mem[rd_ptr];
      bus.ram_we   = 1'b1;
    end
  end

  assign bus.disp_rvalid  = rvalid_q;
  assign bus.disp_rdata   = bus.ram_rdata;
  assign bus.wr_ready     = ready_q;
  assign bus.wr_pending   = count;
  assign bus.frame_commit = commit_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter (both drain modes)
module tb_vram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int FD = 4;
  localparam int CW = $clog2(FD) + 1;
  localparam int NA = 1 << AW;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  logic          disp_req  = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          wr_valid  = 1'b0;
  logic [AW-1:0] wr_addr   = '0;
  logic [DW-1:0] wr_data   = '0;
  logic          v_nblank  = 1'b0;
  logic          end_frame = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Instance 0 drains in any free cycle, instance 1 only in vertical blanking.
  vram_arbiter_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) bus0();
  vram_arbiter_if #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD)) bus1();

  vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD), .VBLANK_ONLY(0)) u0 (
    .sys_clk(sys_clk), .reset(reset), .bus(bus0));
  vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD), .VBLANK_ONLY(1)) u1 (
    .sys_clk(sys_clk), .reset(reset), .bus(bus1));

  logic [DW-1:0] rdata [2];

  assign bus0.disp_req = disp_req;   assign bus1.disp_req = disp_req;
  assign bus0.disp_addr = disp_addr; assign bus1.disp_addr = disp_addr;
  assign bus0.wr_valid = wr_valid;   assign bus1.wr_valid = wr_valid;
  assign bus0.wr_addr = wr_addr;     assign bus1.wr_addr = wr_addr;
  assign bus0.wr_data = wr_data;     assign bus1.wr_data = wr_data;
  assign bus0.v_nblank = v_nblank;   assign bus1.v_nblank = v_nblank;
  assign bus0.EndFrame = end_frame;  assign bus1.EndFrame = end_frame;
  assign bus0.ram_rdata = rdata[0];  assign bus1.ram_rdata = rdata[1];

  logic [1:0]    o_we, o_ready, o_rvalid, o_commit;
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_wdata [2];
  logic [DW-1:0] o_rdata [2];
  logic [CW-1:0] o_pend [2];

  assign o_we[0] = bus0.ram_we;           assign o_we[1] = bus1.ram_we;
  assign o_ready[0] = bus0.wr_ready;      assign o_ready[1] = bus1.wr_ready;
  assign o_rvalid[0] = bus0.disp_rvalid;  assign o_rvalid[1] = bus1.disp_rvalid;
  assign o_commit[0] = bus0.frame_commit; assign o_commit[1] = bus1.frame_commit;
  assign o_addr[0] = bus0.ram_addr;       assign o_addr[1] = bus1.ram_addr;
  assign o_wdata[0] = bus0.ram_wdata;     assign o_wdata[1] = bus1.ram_wdata;
  assign o_rdata[0] = bus0.disp_rdata;    assign o_rdata[1] = bus1.disp_rdata;
  assign o_pend[0] = bus0.wr_pending;     assign o_pend[1] = bus1.wr_pending;

  function automatic logic [DW-1:0] init_val(input int a);
    return DW'(a) ^ 8'h5C;
  endfunction

  // Synchronous single-port RAM per instance; reloaded with a known pattern
  // while reset is held so the model's copy can follow it.
  logic [DW-1:0] mem [2][NA];
  always @(posedge sys_clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        for (int a = 0; a < NA; a++) mem[k][a] <= init_val(a);
      end else if (o_we[k]) begin
        mem[k][o_addr[k]] <= o_wdata[k];
      end
      rdata[k] <= mem[k][o_addr[k]];
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] t=%0t: got 0x%0h, expected 0x%0h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: a FIFO queue of {addr,data}, an image of what RAM must
  // hold, and the frame-commit rule stated as "pulse once all buffered writes
  // landed after the frame boundary".
  logic [AW+DW-1:0] mq [2][FD];
  int               mh [2];
  int               mc [2];
  bit               m_ready [2];
  bit               m_rvalid [2];
  bit               m_commit [2];
  bit               m_flush [2];
  logic [DW-1:0]    m_rd [2];
  logic [DW-1:0]    gold [2][NA];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mc[k] = 0;
      m_ready[k] = 1'b1; m_rvalid[k] = 1'b0; m_commit[k] = 1'b0; m_flush[k] = 1'b0;
      for (int a = 0; a < NA; a++) gold[k][a] = init_val(a);
    end
  endtask

  task automatic model_cycle(input int k);
    logic [AW+DW-1:0] h;
    logic [AW-1:0]    ha;
    bit               dr;
    bit               push;
    int               oc;
    oc   = mc[k];
    h    = mq[k][mh[k]];
    ha   = h[AW+DW-1:DW];
    dr   = (oc != 0) && !disp_req && ((k == 0) || !v_nblank);
    push = wr_valid && m_ready[k];

    chk("wr_pending", k, 32'(o_pend[k]), 32'(oc));
    chk("wr_ready", k, 32'(o_ready[k]), 32'(m_ready[k]));
    chk("disp_rvalid", k, 32'(o_rvalid[k]), 32'(m_rvalid[k]));
    chk("frame_commit", k, 32'(o_commit[k]), 32'(m_commit[k]));
    chk("ram_we", k, 32'(o_we[k]), 32'(dr));
    chk("ram_addr", k, 32'(o_addr[k]), dr ? 32'(ha) : 32'(disp_addr));
    if (dr) chk("ram_wdata", k, 32'(o_wdata[k]), 32'(h[DW-1:0]));
    if (m_rvalid[k]) chk("disp_rdata", k, 32'(o_rdata[k]), 32'(m_rd[k]));

    m_rvalid[k] = disp_req;
    if (disp_req) m_rd[k] = gold[k][disp_addr];
    if (dr) begin
      gold[k][ha] = h[DW-1:0];
      mh[k] = (mh[k] + 1) % FD;
      mc[k] = mc[k] - 1;
    end
    if (push) begin
      mq[k][(mh[k] + mc[k]) % FD] = {wr_addr, wr_data};
      mc[k] = mc[k] + 1;
    end
    m_ready[k] = (mc[k] != FD);

    m_commit[k] = 1'b0;
    if (!m_flush[k]) begin
      if (end_frame) begin
        if (oc == 0 && !push) m_commit[k] = 1'b1;
        else m_flush[k] = 1'b1;
      end
    end else if (oc == 0) begin
      m_commit[k] = 1'b1;
      m_flush[k]  = 1'b0;
    end
  endtask

  // Compare process: inputs are stable from posedge+1, outputs are checked
  // on the falling edge, then the model advances across the next rising edge.
  always @(negedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        chk("rst_wr_pending", k, 32'(o_pend[k]), 0);
        chk("rst_wr_ready", k, 32'(o_ready[k]), 1);
        chk("rst_ram_we", k, 32'(o_we[k]), 0);
        chk("rst_disp_rvalid", k, 32'(o_rvalid[k]), 0);
        chk("rst_frame_commit", k, 32'(o_commit[k]), 0);
      end
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) model_cycle(k);
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge sys_clk);
    #1;
  endtask

  int pulses;
  int pulse_at;
  int thr;

  initial begin
    reset = 1'b1;
    step(); step();
    chk("lit_rst_ready", 0, 32'(o_ready[0]), 1);
    chk("lit_rst_pending", 0, 32'(o_pend[0]), 0);
    reset = 1'b0;

    // Read priority over a simultaneous write offer.
    step();
    disp_req = 1'b1; disp_addr = 8'h10;
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 8'h5A;
    at_neg();
    chk("lit_prio_addr", 0, 32'(o_addr[0]), 32'h10);
    chk("lit_prio_we", 0, 32'(o_we[0]), 0);
    step();
    disp_req = 1'b0; wr_valid = 1'b0;
    at_neg();
    chk("lit_prio_waddr", 0, 32'(o_addr[0]), 32'h20);
    chk("lit_prio_wwe", 0, 32'(o_we[0]), 1);
    chk("lit_prio_wdata", 0, 32'(o_wdata[0]), 32'h5A);
    chk("lit_prio_rvalid", 0, 32'(o_rvalid[0]), 1);

    // Fill under continuous display reads, then drain in order.
    step();
    disp_req = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_addr = AW'(8'h40 + i); wr_data = DW'(8'hC0 + i);
      if (i == 4) begin
        at_neg();
        chk("lit_full_ready", 0, 32'(o_ready[0]), 0);
        chk("lit_full_pending", 0, 32'(o_pend[0]), 4);
      end
      step();
    end
    disp_req = 1'b0;
    for (int j = 0; j < 4; j++) begin
      at_neg();
      chk("lit_drain_we", 0, 32'(o_we[0]), 1);
      chk("lit_drain_addr", 0, 32'(o_addr[0]), 32'(8'h40 + j));
      if (j == 1) chk("lit_drain_ready", 0, 32'(o_ready[0]), 1);
      step();
      if (j == 1) wr_valid = 1'b0;
    end
    step(); step(); step();

    // Push and drain together with two entries held; pointers wrap.
    disp_req = 1'b1; wr_valid = 1'b1; wr_addr = 8'h80; wr_data = 8'h01;
    step();
    wr_addr = 8'h81; wr_data = 8'h02;
    step();
    disp_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_addr = AW'(8'h82 + i); wr_data = DW'(3 + i);
      at_neg();
      chk("lit_pp_pending", 0, 32'(o_pend[0]), 2);
      chk("lit_pp_addr", 0, 32'(o_addr[0]), 32'(8'h80 + i));
      step();
    end
    wr_valid = 1'b0;
    step(); step(); step();

    // Vertical-blank-only instance holds writes during active video.
    v_nblank = 1'b1; wr_valid = 1'b1; wr_addr = 8'h90; wr_data = 8'h11;
    step();
    wr_addr = 8'h91; wr_data = 8'h22;
    step();
    wr_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      at_neg();
      chk("lit_vb_hold", 1, 32'(o_we[1]), 0);
      step();
    end
    chk("lit_vb_pending", 1, 32'(o_pend[1]), 2);
    v_nblank = 1'b0;
    at_neg();
    chk("lit_vb_we0", 1, 32'(o_we[1]), 1);
    chk("lit_vb_addr0", 1, 32'(o_addr[1]), 32'h90);
    step();
    at_neg();
    chk("lit_vb_we1", 1, 32'(o_we[1]), 1);
    chk("lit_vb_addr1", 1, 32'(o_addr[1]), 32'h91);
    step();
    at_neg();
    chk("lit_vb_we2", 1, 32'(o_we[1]), 0);
    step();

    // Frame commit with an empty FIFO.
    end_frame = 1'b1;
    step();
    end_frame = 1'b0;
    at_neg();
    chk("lit_commit_now", 0, 32'(o_commit[0]), 1);
    step();
    at_neg();
    chk("lit_commit_once", 0, 32'(o_commit[0]), 0);
    step();

    // Frame commit after a flush of three writes; second EndFrame absorbed.
    disp_req = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(8'hA0 + i); wr_data = DW'(8'h30 + i);
      step();
    end
    wr_valid = 1'b0; end_frame = 1'b1;
    step();
    end_frame = 1'b0;
    step();
    end_frame = 1'b1;
    step();
    end_frame = 1'b0; disp_req = 1'b0;
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 8; i++) begin
      at_neg();
      if (o_commit[0]) begin
        pulses++;
        pulse_at = i;
      end
      step();
    end
    chk("lit_flush_pulses", 0, 32'(pulses), 1);
    chk("lit_flush_cycle", 0, 32'(pulse_at), 4);

    // Asynchronous reset while three writes are about to drain.
    disp_req = 1'b1; wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = AW'(8'hB0 + i); wr_data = DW'(8'hE0 + i);
      step();
    end
    wr_valid = 1'b0; disp_req = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("lit_arst_pending", 0, 32'(o_pend[0]), 0);
    chk("lit_arst_ready", 0, 32'(o_ready[0]), 1);
    chk("lit_arst_we", 0, 32'(o_we[0]), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      at_neg();
      chk("lit_arst_nowrite", 0, 32'(o_we[0]), 0);
      step();
    end

    // Randomised traffic with varying display-read density.
    for (int c = 0; c < 3000; c++) begin
      thr = (((c / 500) % 3) == 0) ? 92 : 45;
      disp_req  = ($urandom_range(0, 99) < thr);
      disp_addr = AW'($urandom);
      wr_valid  = ($urandom_range(0, 1) == 1);
      wr_addr   = AW'($urandom);
      wr_data   = DW'($urandom);
      if ($urandom_range(0, 39) == 0) v_nblank = ~v_nblank;
      end_frame = ($urandom_range(0, 24) == 0);
      step();
    end
    disp_req = 1'b0; wr_valid = 1'b0; end_frame = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
